fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the two-stage RV32I pipeline. Holds the architectural PC, issues word requests to the instruction memory port, and presents one registered instruction word plus its PC to the decode/control side with a valid/ready handshake. Accepts branch/jump redirects from execute and safely discards any in-flight fetch, keeping the memory request stable until it completes.

## Interface
Parameters:
- RESET_PC, 32'h0000_0200, PC loaded on reset.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  asynchronous, active-low reset.
- iren  output  1  instruction read request to memory.
- iaddr  output  32  word-aligned request address; equals the current fetch PC.
- ihit  input  1  memory completes the request this cycle; irdata valid.
- irdata  input  32  instruction word returned with ihit.
- redirect  input  1  single-cycle pulse: fetch from redirect_pc next.
- redirect_pc  input  32  redirect target.
- instr_valid  output  1  output slot holds a valid instruction.
- instr  output  32  instruction word, to the control unit `instr` input.
- instr_pc  output  32  PC of `instr`.
- decode_ready  input  1  downstream consumes the slot this cycle when instr_valid=1.
- fetch_fault  output  1  misaligned redirect target (only with FETCH_MISALIGN_CHECK_EN; otherwise tied 0).

## Operation
- Registers: pc, slot (instr, instr_pc, instr_valid), state ∈ {FETCH, WAIT, DRAIN, FAULT}.
- Reset: pc=RESET_PC, state=FETCH, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0; iren=0 while nRST low.
- slot_free = !instr_valid || decode_ready.
- FETCH: iren = slot_free. If iren && ihit: slot ← {irdata, pc}, instr_valid=1, pc ← pc+4, stay. If iren && !ihit: → WAIT. If !iren: hold; slot keeps contents.
- WAIT: iren=1, iaddr stable. Slot is empty by construction. On ihit: load slot, pc ← pc+4, → FETCH.
- DRAIN: iren=1, iaddr = stale address held; on ihit data discarded, → FETCH. pc already holds the redirect target.
- Rule: once iren rises, iren and iaddr stay constant until the ihit cycle inclusive.
- Slot consumed (instr_valid && decode_ready) without a new load: instr_valid ← 0.
- Redirect (highest priority over slot load):
  - instr_valid ← 0; returned data in that cycle is discarded; pc ← redirect_pc.
  - iaddr is driven from a separate request-address register, loaded at request issue, so DRAIN keeps the old address while pc holds the target.
  - Next state: request outstanding without ihit this cycle (FETCH with iren && !ihit, WAIT && !ihit, DRAIN && !ihit) → DRAIN; otherwise → FETCH.
  - Redirect during DRAIN updates pc to the newest target; stays DRAIN.
- pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Zero-wait memory (ihit same cycle as iren): request issued in cycle N → instr_valid=1 in N+1; sustained one instruction per cycle while decode_ready=1.
- k wait cycles → instr_valid in cycle N+k+1.
- Redirect in cycle R with no outstanding request: iaddr = target in R+1; first target instruction valid no earlier than R+2.
- Redirect with outstanding request: target request issued the cycle after the stale ihit.
- decode_ready low with valid slot: no new request issued; slot held unchanged.
- Asynchronous reset mid-request: all state cleared immediately; iren drops; any later ihit is ignored until a new request issues.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]≠0 → state FAULT: pc ← redirect_pc, iren=0, instr_valid=0, fetch_fault=1. FAULT is left only on the next aligned redirect (→ FETCH, fetch_fault ← 0) or reset. If a request is outstanding, it drains first and fetch_fault rises on the ihit cycle.
- Not defined: redirect_pc[1:0] forced to 2'b00; FAULT state absent; fetch_fault tied 0.

## Test plan
- Reset, ihit tied 1, decode_ready=1 → iaddr 0x200, 0x204, 0x208 on consecutive cycles; instr_pc trails iaddr by one cycle.
- ihit delayed 3 cycles on 0x204 → iaddr held at 0x204 for 4 cycles with iren=1; instr_valid=0 until the cycle after ihit.
- decode_ready=0 for 2 cycles with slot valid → iren=0, instr/instr_pc unchanged; fetch resumes at next PC on release.
- Redirect to 0x400 during WAIT on 0x208 → iaddr stays 0x208 until ihit; 0x208 data never appears on instr; next iaddr=0x400.
- Redirect to 0x400 in same cycle as ihit on 0x20C → data dropped, instr_valid=0 next cycle, iaddr=0x400.
- With FETCH_MISALIGN_CHECK_EN: redirect to 0x402 → fetch_fault=1, iren=0; redirect to 0x500 → fetch_fault=0, iaddr=0x500. Without the macro: redirect to 0x402 → iaddr=0x400.

Source files
------------

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups every bus signal of the instruction fetch stage.
//   Memory side : iren, iaddr (fetch -> mem), ihit, irdata (mem -> fetch)
//   Execute side: redirect, redirect_pc (execute -> fetch)
//   Decode side : instr_valid, instr, instr_pc, fetch_fault (fetch -> decode),
//                 decode_ready (decode -> fetch)
// Modports: master = the fetch stage itself, slave = its environment.
interface fetch_stage_if;
    logic        iren;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] irdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready;
    logic        fetch_fault;

    modport master (
        output iren, iaddr, instr_valid, instr, instr_pc, fetch_fault,
        input  ihit, irdata, redirect, redirect_pc, decode_ready
    );

    modport slave (
        input  iren, iaddr, instr_valid, instr, instr_pc, fetch_fault,
        output ihit, irdata, redirect, redirect_pc, decode_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the two-stage RV32I pipeline.
// Holds the architectural PC, issues word reads to instruction memory and
// presents one registered instruction (plus its PC) to decode through a
// valid/ready slot. Redirects from execute replace the PC; an in-flight
// memory request is kept stable until its ihit and its data is discarded.
//
// Ports:
//   CLK   - clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - fetch_stage_if.master (memory, redirect and decode signals)
// Parameter:
//   RESET_PC - PC loaded on reset
// Optional build macro:
//   FETCH_MISALIGN_CHECK_EN - a redirect to a non-word-aligned target parks
//   the stage in FAULT and raises fetch_fault. Without it the low two target
//   bits are forced to zero and fetch_fault is tied low.
//
// state | meaning
// FETCH | issue a request whenever the slot can accept data
// WAIT  | request outstanding, its data will be loaded into the slot
// DRAIN | request outstanding after a redirect, its data will be dropped
// FAULT | misaligned redirect target seen; no fetching until aligned redirect
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
`ifdef FETCH_MISALIGN_CHECK_EN
        , FAULT = 2'd3
`endif
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        instr_valid_q;
    logic        slot_free;
    logic        iren_c;
    logic        miss_pending;
    logic [31:0] redirect_target;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        redirect_misaligned;
    logic        fault_pending;
    logic        fetch_fault_q;
`endif

    // iren is combinational because a free slot must be refilled in the
    // same cycle decode consumes it to sustain one instruction per cycle.
    always_comb begin
        slot_free = !instr_valid_q || bus.decode_ready;
        iren_c    = 1'b0;
        case (state)
            FETCH:       iren_c = slot_free;
            WAIT, DRAIN: iren_c = 1'b1;
            default:     iren_c = 1'b0;
        endcase
        iren_c       = iren_c && nRST;
        miss_pending = iren_c && !bus.ihit;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_target     = bus.redirect_pc;
    assign redirect_misaligned = |bus.redirect_pc[1:0];
    assign bus.fetch_fault     = fetch_fault_q;
`else
    assign redirect_target     = bus.redirect_pc & 32'hFFFF_FFFC;
    assign bus.fetch_fault     = 1'b0;
`endif

    // Outside FETCH the request address must not follow pc: during DRAIN
    // pc already holds the redirect target while memory still serves the
    // old request.
    assign bus.iren        = iren_c;
    assign bus.iaddr       = (state == FETCH) ? pc : req_addr;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            req_addr      <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_pending <= 1'b0;
            fetch_fault_q <= 1'b0;
`endif
        end else begin
            if (state == FETCH && iren_c)
                req_addr <= pc;

            if (bus.redirect) begin
                pc            <= redirect_target;
                instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                if (redirect_misaligned) begin
                    if (miss_pending) begin
                        state         <= DRAIN;
                        fault_pending <= 1'b1;
                    end else begin
                        state         <= FAULT;
                        fault_pending <= 1'b0;
                        fetch_fault_q <= 1'b1;
                    end
                end else begin
                    state         <= miss_pending ? DRAIN : FETCH;
                    fault_pending <= 1'b0;
                    fetch_fault_q <= 1'b0;
                end
`else
                state <= miss_pending ? DRAIN : FETCH;
`endif
            end else begin
                if (instr_valid_q && bus.decode_ready)
                    instr_valid_q <= 1'b0;
                case (state)
                    FETCH: begin
                        if (iren_c && bus.ihit) begin
                            instr_q       <= bus.irdata;
                            instr_pc_q    <= pc;
                            instr_valid_q <= 1'b1;
                            pc            <= pc + 32'd4;
                        end else if (iren_c) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.ihit) begin
                            instr_q       <= bus.irdata;
                            instr_pc_q    <= pc;
                            instr_valid_q <= 1'b1;
                            pc            <= pc + 32'd4;
                            state         <= FETCH;
                        end
                    end
                    DRAIN: begin
                        if (bus.ihit) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                            if (fault_pending) begin
                                state         <= FAULT;
                                fault_pending <= 1'b0;
                                fetch_fault_q <= 1'b1;
                            end else begin
                                state <= FETCH;
                            end
`else
                            state <= FETCH;
`endif
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    logic CLK;
    logic nRST;
    int   total;
    int   passed;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_0200)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        total = 0;
        passed = 0;
        nRST = 1'b0;
        bus.ihit = 1'b0;
        bus.irdata = '0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.decode_ready = 1'b1;

        // reset state, ihit high must not raise iren
        tick();
        bus.ihit = 1'b1;
        #1;
        chk("rst_iren", {31'd0, bus.iren}, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_instr_pc", bus.instr_pc, 32'd0);
        chk("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);

        // zero-wait fetch 0x200, 0x204
        nRST = 1'b1;
        bus.irdata = 32'hD000_0200;
        #1;
        chk("c1_iren", {31'd0, bus.iren}, 32'd1);
        chk("c1_iaddr", bus.iaddr, 32'h200);
        chk("c1_valid", {31'd0, bus.instr_valid}, 32'd0);

        tick();
        bus.irdata = 32'hD000_0204;
        #1;
        chk("c2_iaddr", bus.iaddr, 32'h204);
        chk("c2_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("c2_instr", bus.instr, 32'hD000_0200);
        chk("c2_instr_pc", bus.instr_pc, 32'h200);

        // 0x208 waits three cycles
        tick();
        bus.ihit = 1'b0;
        bus.irdata = 32'h0;
        #1;
        chk("c3_iaddr", bus.iaddr, 32'h208);
        chk("c3_instr", bus.instr, 32'hD000_0204);
        chk("c3_instr_pc", bus.instr_pc, 32'h204);

        tick();
        #1;
        chk("c4_iren", {31'd0, bus.iren}, 32'd1);
        chk("c4_iaddr", bus.iaddr, 32'h208);
        chk("c4_valid", {31'd0, bus.instr_valid}, 32'd0);

        tick();
        #1;
        chk("c5_iaddr", bus.iaddr, 32'h208);

        tick();
        bus.ihit = 1'b1;
        bus.irdata = 32'hD000_0208;
        #1;
        chk("c6_iaddr", bus.iaddr, 32'h208);
        chk("c6_iren", {31'd0, bus.iren}, 32'd1);
        chk("c6_valid", {31'd0, bus.instr_valid}, 32'd0);

        // decode stalls two cycles; ihit stays high but must be ignored
        tick();
        bus.decode_ready = 1'b0;
        bus.irdata = 32'hDEAD_BEEF;
        #1;
        chk("c7_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("c7_instr", bus.instr, 32'hD000_0208);
        chk("c7_instr_pc", bus.instr_pc, 32'h208);
        chk("c7_iren", {31'd0, bus.iren}, 32'd0);

        tick();
        #1;
        chk("c8_iren", {31'd0, bus.iren}, 32'd0);
        chk("c8_instr", bus.instr, 32'hD000_0208);
        chk("c8_instr_pc", bus.instr_pc, 32'h208);
        chk("c8_valid", {31'd0, bus.instr_valid}, 32'd1);

        // release; request 0x20C goes to WAIT
        tick();
        bus.decode_ready = 1'b1;
        bus.ihit = 1'b0;
        #1;
        chk("c9_iren", {31'd0, bus.iren}, 32'd1);
        chk("c9_iaddr", bus.iaddr, 32'h20C);
        chk("c9_instr", bus.instr, 32'hD000_0208);

        // redirect to 0x400 while waiting on 0x20C
        tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h400;
        #1;
        chk("c10_iren", {31'd0, bus.iren}, 32'd1);
        chk("c10_iaddr", bus.iaddr, 32'h20C);
        chk("c10_valid", {31'd0, bus.instr_valid}, 32'd0);

        tick();
        bus.redirect = 1'b0;
        #1;
        chk("c11_iaddr", bus.iaddr, 32'h20C);
        chk("c11_iren", {31'd0, bus.iren}, 32'd1);
        chk("c11_valid", {31'd0, bus.instr_valid}, 32'd0);

        tick();
        bus.ihit = 1'b1;
        bus.irdata = 32'hBAD0_020C;
        #1;
        chk("c12_iaddr", bus.iaddr, 32'h20C);

        tick();
        bus.irdata = 32'hD000_0400;
        #1;
        chk("c13_iaddr", bus.iaddr, 32'h400);
        chk("c13_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("c13_iren", {31'd0, bus.iren}, 32'd1);

        // redirect to 0x600 in the same cycle as ihit on 0x404
        tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h600;
        bus.irdata = 32'hBAD0_0404;
        #1;
        chk("c14_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("c14_instr", bus.instr, 32'hD000_0400);
        chk("c14_instr_pc", bus.instr_pc, 32'h400);
        chk("c14_iaddr", bus.iaddr, 32'h404);

        tick();
        bus.redirect = 1'b0;
        bus.irdata = 32'hD000_0600;
        #1;
        chk("c15_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("c15_iaddr", bus.iaddr, 32'h600);

        // misaligned redirect to 0x402
        tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h402;
        bus.irdata = 32'hBAD0_0604;
        #1;
        chk("c16_instr", bus.instr, 32'hD000_0600);
        chk("c16_instr_pc", bus.instr_pc, 32'h600);

        tick();
        bus.redirect_pc = 32'h500;
        bus.irdata = 32'hBAD0_0400;
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("c17_fault", {31'd0, bus.fetch_fault}, 32'd1);
        chk("c17_iren", {31'd0, bus.iren}, 32'd0);
`else
        chk("c17_iaddr", bus.iaddr, 32'h400);
        chk("c17_fault", {31'd0, bus.fetch_fault}, 32'd0);
`endif
        chk("c17_valid", {31'd0, bus.instr_valid}, 32'd0);

        // aligned redirect to 0x500, then to the top word for wrap check
        tick();
        bus.redirect_pc = 32'hFFFF_FFFC;
        bus.irdata = 32'hBAD0_0500;
        #1;
        chk("c18_iaddr", bus.iaddr, 32'h500);
        chk("c18_fault", {31'd0, bus.fetch_fault}, 32'd0);
        chk("c18_iren", {31'd0, bus.iren}, 32'd1);

        tick();
        bus.redirect = 1'b0;
        bus.irdata = 32'hD000_FFFC;
        #1;
        chk("c19_iaddr", bus.iaddr, 32'hFFFF_FFFC);
        chk("c19_valid", {31'd0, bus.instr_valid}, 32'd0);

        tick();
        bus.ihit = 1'b0;
        #1;
        chk("c20_iaddr_wrap", bus.iaddr, 32'h0);
        chk("c20_instr", bus.instr, 32'hD000_FFFC);
        chk("c20_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);

        tick();
        #1;
        chk("c21_iren", {31'd0, bus.iren}, 32'd1);
        chk("c21_iaddr", bus.iaddr, 32'h0);
        chk("c21_valid", {31'd0, bus.instr_valid}, 32'd0);

        // asynchronous reset in the middle of the outstanding request
        nRST = 1'b0;
        bus.ihit = 1'b1;
        bus.irdata = 32'hBAD0_0000;
        #1;
        chk("ar_iren", {31'd0, bus.iren}, 32'd0);
        chk("ar_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("ar_instr", bus.instr, 32'd0);
        chk("ar_instr_pc", bus.instr_pc, 32'd0);

        tick();
        tick();
        nRST = 1'b1;
        bus.ihit = 1'b0;
        #1;
        chk("ar_rel_iaddr", bus.iaddr, 32'h200);
        chk("ar_rel_iren", {31'd0, bus.iren}, 32'd1);
        chk("ar_rel_valid", {31'd0, bus.instr_valid}, 32'd0);

        tick();
        #1;
        chk("ar_wait_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("ar_wait_iaddr", bus.iaddr, 32'h200);

        tick();
        bus.ihit = 1'b1;
        bus.irdata = 32'hD000_0200;
        #1;
        chk("ar_hit_iaddr", bus.iaddr, 32'h200);

        tick();
        bus.ihit = 1'b0;
        #1;
        chk("ar_end_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("ar_end_instr", bus.instr, 32'hD000_0200);
        chk("ar_end_instr_pc", bus.instr_pc, 32'h200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
